// File: rtl/ahb_interrupt_controller_if.sv
// AHB-Lite bus bundle between the multiplexor (master side) and a satellite (slave side).
// hready is the multiplexed bus ready seen by every satellite.
interface ahb_interrupt_controller_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_interrupt_controller.sv
// AHB-Lite interrupt controller: latches up to NUM_SRC sources, fixed lowest-index priority,
// claim/complete handshake through offset 0x0C, single registered irq_out.
module ahb_interrupt_controller #(
  parameter int NUM_SRC = 32
) (
  input  logic                               clk,
  input  logic                               nrst,
  ahb_interrupt_controller_if.slave          bus,
  input  logic [31:0]                        irq_src,
  output logic                               irq_out,
  output logic [1:0]                         dbg_state
);

  localparam logic [31:0] IMPL_MASK =
    (NUM_SRC >= 32) ? 32'hFFFF_FFFF : ((32'h1 << NUM_SRC) - 32'h1);

  // Bus handshake: a transfer is taken when hsel & htrans[1] & hready are high at a clock
  // edge; its data phase completes at the next edge where hready is high. Good transfers
  // use zero wait states; bad ones get the two-cycle ERROR response and no side effects.
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_t;

  resp_state_t resp_state;
  logic        hreadyout_q;
  logic        hresp_q;

  logic [31:0] pending;
  logic [31:0] enable;
  logic [31:0] edge_type;
  logic [31:0] inservice;
  logic [31:0] src_prev;
  logic        irq_q;

  logic        dp_valid;
  logic        dp_write;
  logic [2:0]  dp_addr;

  logic        addr_accept;
  logic        addr_err;
  logic        dp_done;
  logic [31:0] eligible;
  logic [5:0]  claim_id;
  logic [31:0] rd_mux;
  logic        claim_fire;
  logic [31:0] claim_vec;
  logic        cmpl_hit;
  logic [31:0] cmpl_vec;
  logic [31:0] rise;
  logic [31:0] pending_next;
  logic [31:0] inservice_next;
  logic        unused_bits;

  assign addr_accept = bus.hsel & bus.htrans[1] & bus.hready;
  assign addr_err    = (bus.haddr[4:0] > 5'h10) | (bus.hsize != 3'b010);
  assign dp_done     = dp_valid & bus.hready;
  assign eligible    = pending & enable & ~inservice;
  assign unused_bits = &{1'b0, bus.haddr[31:5], bus.haddr[1:0], bus.htrans[0]};

  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) claim_id = 6'(i + 1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (dp_addr)
      3'd0:    rd_mux = pending;
      3'd1:    rd_mux = enable;
      3'd2:    rd_mux = edge_type;
      3'd3:    rd_mux = {26'd0, claim_id};
      3'd4:    rd_mux = inservice;
      default: rd_mux = '0;
    endcase
  end

  assign claim_fire = dp_done & ~dp_write & (dp_addr == 3'd3) & (claim_id != 6'd0);
  assign claim_vec  = claim_fire ? (32'h1 << (claim_id - 6'd1)) : 32'h0;

  // Out-of-range IDs and IDs of sources not in service simply clear nothing.
  assign cmpl_hit = dp_done & dp_write & (dp_addr == 3'd3) &
                    (bus.hwdata != 32'd0) & (bus.hwdata <= 32'(NUM_SRC));
  assign cmpl_vec = cmpl_hit ? (32'h1 << (bus.hwdata[4:0] - 5'd1)) : 32'h0;

  // Edge sources: a new rising edge beats a simultaneous claim clear.
  assign rise           = irq_src & ~src_prev;
  assign pending_next   = IMPL_MASK & ((edge_type & ((pending & ~claim_vec) | rise)) |
                                       (~edge_type & irq_src));
  assign inservice_next = IMPL_MASK & ((inservice & ~cmpl_vec) | claim_vec);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      resp_state  <= ST_OKAY;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      pending     <= '0;
      enable      <= '0;
      edge_type   <= '0;
      inservice   <= '0;
      src_prev    <= '0;
      irq_q       <= 1'b0;
      dp_valid    <= 1'b0;
      dp_write    <= 1'b0;
      dp_addr     <= '0;
    end else begin
      pending   <= pending_next;
      inservice <= inservice_next;
      src_prev  <= irq_src;
      irq_q     <= |eligible;

      if (dp_done && dp_write && dp_addr == 3'd1) enable    <= bus.hwdata & IMPL_MASK;
      if (dp_done && dp_write && dp_addr == 3'd2) edge_type <= bus.hwdata & IMPL_MASK;

      if (bus.hready) begin
        dp_valid <= addr_accept & ~addr_err;
        dp_write <= bus.hwrite;
        dp_addr  <= bus.haddr[4:2];
      end

      case (resp_state)
        ST_ERR1: begin
          resp_state  <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (addr_accept && addr_err) begin
            resp_state  <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            resp_state  <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.hrdata    = dp_valid ? rd_mux : 32'h0;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign irq_out       = irq_q;
  assign dbg_state     = resp_state;

endmodule

// File: tb/tb_ahb_interrupt_controller.sv
// Randomised plus directed bench: a per-source reference model predicts every bus response
// and irq_out each cycle; a monitor pops predictions when the DUT completes a data phase.
module tb_ahb_interrupt_controller;
  localparam int N = 20;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] irq_src = '0;
  logic        irq_out;
  logic [1:0]  dbg_state;
  bit          rand_src = 1'b0;
  bit          armed = 1'b0;

  ahb_interrupt_controller_if bus();
  assign bus.hready = bus.hreadyout;

  ahb_interrupt_controller #(.NUM_SRC(N)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .irq_src   (irq_src),
    .irq_out   (irq_out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];  // {error response, is read, read data}

  // ---------------- reference model ----------------
  bit          m_pend[32];
  bit          m_en[32];
  bit          m_edge[32];
  bit          m_insvc[32];
  bit          m_prev[32];
  bit          m_irq = 1'b0;
  bit          m_hready = 1'b1;
  bit          m_dp_ok = 1'b0;
  bit          m_dp_wr = 1'b0;
  logic [4:0]  m_dp_off = '0;
  int          m_dp_id = 0;

  function automatic int model_claim_id();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && !m_insvc[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] off);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (off)
        5'h00: r[i] = m_pend[i];
        5'h04: r[i] = m_en[i];
        5'h08: r[i] = m_edge[i];
        5'h10: r[i] = m_insvc[i];
        default: ;
      endcase
    end
    if (off == 5'h0C) r = 32'(model_claim_id());
    return r;
  endfunction

  always @(posedge clk) begin : model_step
    int cid;
    bit any;
    bit err;
    logic [31:0] wd;
    armed = 1'b1;
    if (!nrst) begin
      for (int i = 0; i < 32; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_insvc[i] = 0; m_prev[i] = 0;
      end
      m_irq = 0; m_hready = 1; m_dp_ok = 0;
    end else begin
      cid = (m_dp_ok && !m_dp_wr && m_dp_off == 5'h0C) ? m_dp_id : 0;
      wd  = bus.hwdata;
      any = 0;
      for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i] && !m_insvc[i]) any = 1;
      for (int i = 0; i < N; i++) begin
        if (m_edge[i]) begin
          if (cid == i + 1) m_pend[i] = 0;
          if (irq_src[i] && !m_prev[i]) m_pend[i] = 1;
        end else begin
          m_pend[i] = irq_src[i];
        end
        m_prev[i] = irq_src[i];
      end
      if (cid != 0) m_insvc[cid - 1] = 1;
      if (m_dp_ok && m_dp_wr) begin
        case (m_dp_off)
          5'h04: for (int i = 0; i < N; i++) m_en[i] = wd[i];
          5'h08: for (int i = 0; i < N; i++) m_edge[i] = wd[i];
          5'h0C: if (wd >= 32'd1 && wd <= 32'(N)) m_insvc[int'(wd) - 1] = 0;
          default: ;
        endcase
      end
      m_irq = any;
      if (bus.hsel && bus.htrans[1] && m_hready) begin
        err = (bus.haddr[4:0] > 5'h10) || (bus.hsize != 3'b010);
        exp_q.push_back({err, !bus.hwrite, model_read(bus.haddr[4:0])});
        m_dp_ok  = !err;
        m_dp_wr  = bus.hwrite;
        m_dp_off = bus.haddr[4:0];
        m_dp_id  = model_claim_id();
        m_hready = !err;
      end else begin
        m_dp_ok  = 0;
        m_hready = 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_active = 1'b0;
  int wait_cnt = 0;
  bit first_ok = 1'b1;

  always @(negedge clk) begin : monitor
    logic [33:0] e;
    if (armed) begin
      checks++;
      if (irq_out !== m_irq) begin
        errors++;
        $display("FAIL irq_out at %0t: got %b expected %b", $time, irq_out, m_irq);
      end
    end
    if (mon_active) begin
      if (bus.hreadyout !== 1'b1) begin
        wait_cnt++;
        if (bus.hresp !== 1'b1) first_ok = 1'b0;
        if (wait_cnt > 4) begin
          checks++; errors++;
          $display("FAIL hreadyout_stuck at %0t: got %0d wait cycles expected at most 1", $time, wait_cnt);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          mon_active = 1'b0; wait_cnt = 0; first_ok = 1'b1;
        end
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response at %0t: got a data phase expected none", $time);
        end else begin
          e = exp_q.pop_front();
          if (e[33]) begin
            if (!(wait_cnt == 1 && first_ok && bus.hresp === 1'b1)) begin
              errors++;
              $display("FAIL error_resp at %0t: got waits=%0d first_hresp_ok=%0d hresp=%b expected waits=1 first_hresp_ok=1 hresp=1",
                       $time, wait_cnt, first_ok, bus.hresp);
            end
          end else begin
            if (!(wait_cnt == 0 && bus.hresp === 1'b0)) begin
              errors++;
              $display("FAIL okay_resp at %0t: got waits=%0d hresp=%b expected waits=0 hresp=0",
                       $time, wait_cnt, bus.hresp);
            end
            if (e[32]) begin
              checks++;
              if (bus.hrdata !== e[31:0]) begin
                errors++;
                $display("FAIL read_data at %0t: got %h expected %h", $time, bus.hrdata, e[31:0]);
              end
            end
          end
        end
        wait_cnt = 0; first_ok = 1'b1;
      end
    end
    if (!nrst) mon_active = 1'b0;
    else if (bus.hreadyout === 1'b1) mon_active = bus.hsel && bus.htrans[1];
  end

  // ---------------- drivers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata);
    int n;
    n = 0;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = addr; bus.hwrite = wr; bus.hsize = size;
    do begin
      @(posedge clk);
      n++;
    end while (bus.hready !== 1'b1 && n < 8);
    if (bus.hready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL addr_phase_timeout: got hready=%b for %0d cycles expected 1", bus.hready, n);
    end
    #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wdata;
  endtask

  task automatic rd(input logic [31:0] addr);
    xfer(addr, 1'b0, 3'b010, $urandom);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    xfer(addr, 1'b1, 3'b010, data);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  always @(posedge clk) begin
    if (rand_src) begin
      #1;
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ (32'h1 << $urandom_range(0, 31));
    end
  end

  initial begin
    bus.hsel = 0; bus.haddr = 0; bus.htrans = 0; bus.hwrite = 0; bus.hsize = 3'b010; bus.hwdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    check("reset_hresp", {31'd0, bus.hresp}, 32'd0);
    check("reset_irq_out", {31'd0, irq_out}, 32'd0);
    check("reset_hrdata", bus.hrdata, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    nrst = 1'b1;
    rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C); rd(32'h10);
    idle(2);

    // Edge source 16: detection, claim returns 17, complete 17.
    wr(32'h04, 32'h0001_0000); wr(32'h08, 32'h0001_0000); idle(2);
    irq_src[16] = 1'b1; idle(1);
    irq_src[16] = 1'b0;
    check("edge_irq_before", {31'd0, irq_out}, 32'd0);
    idle(1);
    check("edge_irq_after", {31'd0, irq_out}, 32'd1);
    rd(32'h00); rd(32'h0C); rd(32'h10); rd(32'h00); idle(2);
    check("edge_irq_dropped", {31'd0, irq_out}, 32'd0);
    wr(32'h0C, 32'd17); rd(32'h10); idle(2);

    // Level sources 3 and 5: claims 4, 6, 0; complete 4 while source 3 still high.
    wr(32'h08, 32'h0); wr(32'h04, 32'h28);
    irq_src[3] = 1'b1; irq_src[5] = 1'b1; idle(3);
    rd(32'h0C); rd(32'h0C); rd(32'h0C); idle(1);
    wr(32'h0C, 32'd4); idle(3);
    rd(32'h0C); idle(1);
    irq_src[3] = 1'b0; irq_src[5] = 1'b0;
    wr(32'h0C, 32'd4); wr(32'h0C, 32'd6); idle(3);

    // Edge source 2: new rising edge during its own claim data phase keeps it pending.
    wr(32'h04, 32'h4); wr(32'h08, 32'h4); idle(1);
    irq_src[2] = 1'b1; idle(1);
    irq_src[2] = 1'b0; idle(2);
    rd(32'h0C);
    irq_src[2] = 1'b1; idle(1);
    irq_src[2] = 1'b0;
    rd(32'h00); rd(32'h10); wr(32'h0C, 32'd3); idle(2);

    // Error responses: bad offset, halfword access; ENABLE untouched.
    rd(32'h14); xfer(32'h04, 1'b1, 3'b001, 32'hFFFF); rd(32'h04);
    xfer(32'h1C, 1'b1, 3'b010, 32'h5); rd(32'h04); idle(2);

    // Ignored completes / PENDING writes; unimplemented ENABLE bits read 0.
    wr(32'h0C, 32'd0); wr(32'h0C, 32'd40); wr(32'h0C, 32'd21);
    wr(32'h00, 32'hFFFF_FFFF); rd(32'h00); rd(32'h10);
    wr(32'h04, 32'hFFFF_FFFF); rd(32'h04); idle(2);

    // Randomised traffic with wandering sources.
    rand_src = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
      case ($urandom_range(0, 9))
        0: addr = 32'h00;
        1, 9: addr = 32'h04;
        2: addr = 32'h08;
        3, 4, 5: addr = 32'h0C;
        6: addr = 32'h10;
        7: addr = 32'h14;
        default: addr = 32'h1C;
      endcase
      size = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b010;
      data = (addr == 32'h0C) ? 32'($urandom_range(0, 23)) : $urandom;
      xfer(addr, 1'($urandom_range(0, 1)), size, data);
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
    end
    rand_src = 1'b0;
    idle(3);

    // Reset during a claim data phase discards the claim.
    irq_src = '0;
    wr(32'h04, 32'h80); wr(32'h08, 32'h80); idle(2);
    irq_src[7] = 1'b1; idle(1);
    irq_src[7] = 1'b0; idle(3);
    rd(32'h0C);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    check("midreset_irq_out", {31'd0, irq_out}, 32'd0);
    check("midreset_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    check("midreset_hrdata", bus.hrdata, 32'd0);
    rd(32'h10); rd(32'h00); rd(32'h04); rd(32'h08); idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
